man_draw_datapath: RTL and testbench
====================================

Name: man_draw_datapath

Overview:
- Datapath driven by the running-man control FSM.
- Consumes its strobes: drawing_floors, erase, ld_x, ld_y, ld_man_style, update, draw_man, reset_frame_counter.
- Returns the FSM's completion flags and frameCounter.
- Emits per-pixel coordinates and colour to the VGA adapter; the FSM's writeEn qualifies each pixel in the same cycle.

Parameters:
- SCREEN_W, 160, screen width in pixels.
- SCREEN_H, 120, screen height in pixels.
- FLOOR_Y, 100, first floor row; floor occupies rows FLOOR_Y..SCREEN_H-1.
- MAN_W, 4, sprite width (power of 2).
- MAN_H, 8, sprite height (power of 2).
- X_START, 10, man x after reset.
- STEP, 1, x advance per update.
- JUMP_H, 12, rows climbed per jump.
- DELAY_CYCLES, 833333, clocks per frame tick (50 MHz / 60 Hz).
- BG_COLOUR, 3'b000, background and erase colour.
- MAN_COLOUR, 3'b111, sprite colour.
- FLOOR_COLOUR, 3'b010, floor colour.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- drawing_floors, in, 1, floor scan active.
- erase, in, 1, erase scan of latched sprite box.
- draw_man, in, 1, sprite scan active.
- ld_x, in, 1, load draw_x from man_x.
- ld_y, in, 1, load draw_y from man_y.
- ld_man_style, in, 1, load draw_style from man_style.
- update, in, 1, one-cycle position/style update.
- reset_frame_counter, in, 1, active-low synchronous clear of frame timing.
- jump, in, 1, level jump request (synchronised key).
- x_out, out, 8, pixel x.
- y_out, out, 7, pixel y.
- colour, out, 3, pixel colour.
- draw_floors_finish, out, 1, last floor pixel presented.
- erase_finish, out, 1, last erase pixel presented.
- draw_man_finish, out, 1, last sprite pixel presented.
- frameCounter, out, 4, frame ticks since last clear.

Behaviour:
- Reset (async, reset_n=0):
  - man_x=draw_x=X_START; man_y=draw_y=FLOOR_Y-MAN_H (92); man_style=draw_style=0.
  - rising=0; jump_cnt=0; pix counters=0; delay=0; frameCounter=0.
  - x_out=0, y_out=0, colour=BG_COLOUR, all finish flags 0.
- Mode priority: drawing_floors > erase > draw_man. No mode high: both scan counters clear to 0, outputs hold reset values, finishes 0.
- Dropping a mode mid-scan (FSM reset or abort): counters clear on the next edge; the next scan restarts at pixel 0.
- Floor scan:
  - Counters fx (0..SCREEN_W-1) and fy (FLOOR_Y..SCREEN_H-1); x-major.
  - x_out=fx, y_out=fy, colour=FLOOR_COLOUR. Outputs are combinational from counters, so pixel N appears in cycle N of the mode with zero latency.
  - draw_floors_finish is combinational, high only while (fx,fy)=(SCREEN_W-1,SCREEN_H-1); counters wrap to (0,FLOOR_Y) on that edge.
- Sprite scan (erase or draw_man):
  - Counter sc, 0..MAN_W*MAN_H-1.
  - col=sc mod MAN_W; row=sc/MAN_W; x_out=draw_x+col; y_out=draw_y+row.
  - erase: colour=BG_COLOUR.
  - draw_man: colour=MAN_COLOUR if the pattern bit is set, else BG_COLOUR.
  - Pattern, 4x8 default:
    - row0 cols1-2 (head);
    - rows1-5 all cols;
    - rows6-7: style0 cols0,3; style1 cols1,2.
  - erase_finish / draw_man_finish high only in the sc=MAN_W*MAN_H-1 cycle of that mode; sc then returns to 0.
- Loads: ld_x/ld_y/ld_man_style copy man_* into draw_* on the edge, each independently. Erase therefore always uses the previously drawn box, because the FSM erases before it updates.
- update (single-cycle strobe), all changes on one edge:
  - x: man_x = (man_x+STEP > SCREEN_W-MAN_W) ? 0 : man_x+STEP.
  - style: man_style toggles.
  - y, in priority order:
    - rising: man_y-1; jump_cnt-1; rising clears when jump_cnt reaches 0.
    - man_y < FLOOR_Y-MAN_H (falling): man_y+1.
    - on floor and jump=1: rising=1, jump_cnt=JUMP_H, no y move this update.
  - jump is ignored while airborne.
  - update together with a scan mode is an FSM error; update still applies.
- Frame timing:
  - delay counts 0..DELAY_CYCLES-1. On wrap, frameCounter increments, modulo 16.
  - reset_frame_counter=0 clears delay and frameCounter synchronously and overrides a same-cycle increment.

Test Plan:
1. Assert reset_n=0 mid floor scan, then release -> outputs at reset values; the next floor scan starts at (0,100).
2. drawing_floors held 3200 cycles -> cycle1 (0,100) colour 010; cycle3200 (159,119) with draw_floors_finish=1; never earlier.
3. ld_* pulse then draw_man 32 cycles at man (10,92), style0 -> cycle1 (10,92) colour 000, cycle2 (11,92) 111, cycle32 (13,99) 111 with finish. Drop draw_man at cycle 10 and reassert -> restarts at (10,92).
4. update with man_x=155 -> 156; again -> 0; man_style toggles each time. Erase after that update still scans the old box (156,92).
5. jump=1 on floor, 25 updates -> y sequence 92, 91..80 (12 steps), then 81..92; jump held while airborne has no effect.
6. DELAY_CYCLES=4: after 56 clocks frameCounter=14; reset_frame_counter=0 for one cycle coinciding with a wrap -> frameCounter=0, delay=0.

Source files
------------

// File: rtl/man_draw_datapath.sv
// Running-man datapath: floor and sprite pixel scans, man position/jump state,
// and the frame tick counter that paces the control FSM.
module man_draw_datapath #(
    parameter int unsigned SCREEN_W     = 160,
    parameter int unsigned SCREEN_H     = 120,
    parameter int unsigned FLOOR_Y      = 100,
    parameter int unsigned MAN_W        = 4,
    parameter int unsigned MAN_H        = 8,
    parameter int unsigned X_START      = 10,
    parameter int unsigned STEP         = 1,
    parameter int unsigned JUMP_H       = 12,
    parameter int unsigned DELAY_CYCLES = 833333,
    parameter logic [2:0]  BG_COLOUR    = 3'b000,
    parameter logic [2:0]  MAN_COLOUR   = 3'b111,
    parameter logic [2:0]  FLOOR_COLOUR = 3'b010
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       drawing_floors,
    input  logic       erase,
    input  logic       draw_man,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       ld_man_style,
    input  logic       update,
    input  logic       reset_frame_counter,
    input  logic       jump,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       draw_floors_finish,
    output logic       erase_finish,
    output logic       draw_man_finish,
    output logic [3:0] frameCounter
);

    localparam int unsigned FROWS    = SCREEN_H - FLOOR_Y;
    localparam int unsigned FRW      = $clog2(FROWS);
    localparam int unsigned SCW      = $clog2(MAN_W * MAN_H);
    localparam int unsigned CW       = $clog2(MAN_W);
    localparam int unsigned RW       = SCW - CW;
    localparam int unsigned JW       = $clog2(JUMP_H + 1);
    localparam int unsigned DW       = $clog2(DELAY_CYCLES);
    localparam int unsigned GROUND_Y = FLOOR_Y - MAN_H;

    localparam logic [7:0]     FX_LAST = 8'(SCREEN_W - 1);
    localparam logic [FRW-1:0] FY_LAST = FRW'(FROWS - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(MAN_W * MAN_H - 1);

    logic [7:0]     man_x_q, man_x_d, draw_x_q, draw_x_d;
    logic [6:0]     man_y_q, man_y_d, draw_y_q, draw_y_d;
    logic           man_style_q, man_style_d, draw_style_q, draw_style_d;
    logic           rising_q, rising_d;
    logic [JW-1:0]  jump_cnt_q, jump_cnt_d;
    logic [7:0]     fx_q, fx_d;
    logic [FRW-1:0] fy_q, fy_d;
    logic [SCW-1:0] sc_q, sc_d;
    logic [DW-1:0]  delay_q, delay_d;
    logic [3:0]     frame_q, frame_d;

    logic           floor_mode, erase_mode, man_mode, sprite_mode;
    logic           fx_last, fy_last, sc_last;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [8:0]     x_next;

    // Sprite mask: head on the top row, solid torso, legs alternate by style.
    function automatic logic man_pixel(logic [RW-1:0] r, logic [CW-1:0] c, logic style);
        logic mid;
        logic edge_col;
        mid      = (c == CW'(MAN_W / 2 - 1)) || (c == CW'(MAN_W / 2));
        edge_col = (c == '0) || (c == CW'(MAN_W - 1));
        if (r == '0) begin
            return mid;
        end else if (r < RW'(MAN_H - 2)) begin
            return 1'b1;
        end else begin
            return style ? mid : edge_col;
        end
    endfunction

    assign floor_mode  = drawing_floors;
    assign erase_mode  = !drawing_floors && erase;
    assign man_mode    = !drawing_floors && !erase && draw_man;
    assign sprite_mode = erase_mode || man_mode;

    assign fx_last = (fx_q == FX_LAST);
    assign fy_last = (fy_q == FY_LAST);
    assign sc_last = (sc_q == SC_LAST);
    assign col     = sc_q[CW-1:0];
    assign row     = sc_q[SCW-1:CW];
    assign x_next  = {1'b0, man_x_q} + 9'(STEP);

    assign frameCounter = frame_q;

    always_comb begin
        x_out              = '0;
        y_out              = '0;
        colour             = BG_COLOUR;
        draw_floors_finish = 1'b0;
        erase_finish       = 1'b0;
        draw_man_finish    = 1'b0;
        if (floor_mode) begin
            x_out              = fx_q;
            y_out              = 7'(FLOOR_Y) + 7'(fy_q);
            colour             = FLOOR_COLOUR;
            draw_floors_finish = fx_last && fy_last;
        end else if (sprite_mode) begin
            x_out = draw_x_q + 8'(col);
            y_out = draw_y_q + 7'(row);
            if (erase_mode) begin
                erase_finish = sc_last;
            end else begin
                colour          = man_pixel(row, col, draw_style_q) ? MAN_COLOUR : BG_COLOUR;
                draw_man_finish = sc_last;
            end
        end
    end

    // Scan counters fall back to pixel 0 whenever their mode is not selected.
    always_comb begin
        fx_d = '0;
        fy_d = '0;
        sc_d = '0;
        if (floor_mode) begin
            if (fx_last) begin
                fy_d = fy_last ? '0 : fy_q + 1'b1;
            end else begin
                fx_d = fx_q + 1'b1;
                fy_d = fy_q;
            end
        end
        if (sprite_mode && !sc_last) begin
            sc_d = sc_q + 1'b1;
        end
    end

    always_comb begin
        man_x_d      = man_x_q;
        man_y_d      = man_y_q;
        man_style_d  = man_style_q;
        rising_d     = rising_q;
        jump_cnt_d   = jump_cnt_q;
        draw_x_d     = ld_x ? man_x_q : draw_x_q;
        draw_y_d     = ld_y ? man_y_q : draw_y_q;
        draw_style_d = ld_man_style ? man_style_q : draw_style_q;
        if (update) begin
            man_x_d     = (x_next > 9'(SCREEN_W - MAN_W)) ? 8'd0 : x_next[7:0];
            man_style_d = !man_style_q;
            if (rising_q) begin
                man_y_d    = man_y_q - 1'b1;
                jump_cnt_d = jump_cnt_q - 1'b1;
                rising_d   = (jump_cnt_q != JW'(1));
            end else if (man_y_q < 7'(GROUND_Y)) begin
                man_y_d = man_y_q + 1'b1;
            end else if (jump) begin
                rising_d   = 1'b1;
                jump_cnt_d = JW'(JUMP_H);
            end
        end
    end

    always_comb begin
        delay_d = delay_q + 1'b1;
        frame_d = frame_q;
        if (!reset_frame_counter) begin
            delay_d = '0;
            frame_d = '0;
        end else if (delay_q == DW'(DELAY_CYCLES - 1)) begin
            delay_d = '0;
            frame_d = frame_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            man_x_q      <= 8'(X_START);
            man_y_q      <= 7'(GROUND_Y);
            man_style_q  <= 1'b0;
            draw_x_q     <= 8'(X_START);
            draw_y_q     <= 7'(GROUND_Y);
            draw_style_q <= 1'b0;
            rising_q     <= 1'b0;
            jump_cnt_q   <= '0;
            fx_q         <= '0;
            fy_q         <= '0;
            sc_q         <= '0;
            delay_q      <= '0;
            frame_q      <= '0;
        end else begin
            man_x_q      <= man_x_d;
            man_y_q      <= man_y_d;
            man_style_q  <= man_style_d;
            draw_x_q     <= draw_x_d;
            draw_y_q     <= draw_y_d;
            draw_style_q <= draw_style_d;
            rising_q     <= rising_d;
            jump_cnt_q   <= jump_cnt_d;
            fx_q         <= fx_d;
            fy_q         <= fy_d;
            sc_q         <= sc_d;
            delay_q      <= delay_d;
            frame_q      <= frame_d;
        end
    end

endmodule

// File: tb/tb_man_draw_datapath.sv
// Scoreboard bench for man_draw_datapath: stimulus queues expected pixels,
// a negedge monitor pops and compares them whenever a scan mode is active.
module tb_man_draw_datapath;

    logic       clk = 1'b0;
    logic       reset_n, drawing_floors, erase, draw_man;
    logic       ld_x, ld_y, ld_man_style, update, reset_frame_counter, jump;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour;
    logic       draw_floors_finish, erase_finish, draw_man_finish;
    logic [3:0] frameCounter;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       ff;
        logic       ef;
        logic       mf;
    } pix_t;

    pix_t       exp_q[$];
    pix_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] pat [2][8];

    always #5 clk = ~clk;

    man_draw_datapath #(.DELAY_CYCLES(4)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .drawing_floors      (drawing_floors),
        .erase               (erase),
        .draw_man            (draw_man),
        .ld_x                (ld_x),
        .ld_y                (ld_y),
        .ld_man_style        (ld_man_style),
        .update              (update),
        .reset_frame_counter (reset_frame_counter),
        .jump                (jump),
        .x_out               (x_out),
        .y_out               (y_out),
        .colour              (colour),
        .draw_floors_finish  (draw_floors_finish),
        .erase_finish        (erase_finish),
        .draw_man_finish     (draw_man_finish),
        .frameCounter        (frameCounter)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (drawing_floors || erase || draw_man) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pixel: x=%0d y=%0d with no expectation queued at %0t",
                         x_out, y_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pix_x", 32'(x_out), 32'(mon_e.x));
                chk("pix_y", 32'(y_out), 32'(mon_e.y));
                chk("pix_colour", 32'(colour), 32'(mon_e.c));
                chk("pix_finish", 32'({draw_floors_finish, erase_finish, draw_man_finish}),
                    32'({mon_e.ff, mon_e.ef, mon_e.mf}));
            end
        end else begin
            chk("idle_outputs",
                32'({x_out, y_out, colour, draw_floors_finish, erase_finish, draw_man_finish}), 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_floor(input int n);
        pix_t p;
        int   cnt = 0;
        for (int y = 100; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                if (cnt < n) begin
                    p.x  = 8'(x);
                    p.y  = 7'(y);
                    p.c  = 3'b010;
                    p.ff = (x == 159) && (y == 119);
                    p.ef = 1'b0;
                    p.mf = 1'b0;
                    exp_q.push_back(p);
                end
                cnt++;
            end
        end
    endtask

    task automatic push_sprite(input int x0, input int y0, input int style,
                               input bit is_erase, input int n);
        pix_t p;
        for (int i = 0; i < n; i++) begin
            p.x  = 8'(x0 + i % 4);
            p.y  = 7'(y0 + i / 4);
            p.c  = (!is_erase && pat[style][i/4][i%4]) ? 3'b111 : 3'b000;
            p.ff = 1'b0;
            p.ef = is_erase && (i == 31);
            p.mf = !is_erase && (i == 31);
            exp_q.push_back(p);
        end
    endtask

    // 0 = floors, 1 = erase, 2 = draw_man; one idle cycle afterwards clears the counters.
    task automatic run_mode(input int which, input int n);
        case (which)
            0:       drawing_floors = 1'b1;
            1:       erase = 1'b1;
            default: draw_man = 1'b1;
        endcase
        repeat (n) tick();
        drawing_floors = 1'b0;
        erase          = 1'b0;
        draw_man       = 1'b0;
        tick();
    endtask

    task automatic load();
        ld_x = 1'b1; ld_y = 1'b1; ld_man_style = 1'b1;
        tick();
        ld_x = 1'b0; ld_y = 1'b0; ld_man_style = 1'b0;
    endtask

    task automatic do_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int yexp;
        for (int r = 0; r < 8; r++) begin
            pat[0][r] = 4'b1111;
            pat[1][r] = 4'b1111;
        end
        pat[0][0] = 4'b0110; pat[1][0] = 4'b0110;
        pat[0][6] = 4'b1001; pat[0][7] = 4'b1001;
        pat[1][6] = 4'b0110; pat[1][7] = 4'b0110;

        reset_n = 1'b0; drawing_floors = 1'b0; erase = 1'b0; draw_man = 1'b0;
        ld_x = 1'b0; ld_y = 1'b0; ld_man_style = 1'b0; update = 1'b0;
        reset_frame_counter = 1'b1; jump = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        chk("reset_frameCounter", 32'(frameCounter), 32'd0);
        tick();

        // Reset dropped in mid floor scan; the next scan restarts at (0,100).
        push_floor(5);
        drawing_floors = 1'b1;
        repeat (5) tick();
        drawing_floors = 1'b0;
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        push_floor(3200);
        run_mode(0, 3200);

        // Sprite at (10,92) style 0, with an aborted scan first.
        load();
        push_sprite(10, 92, 0, 1'b0, 10);
        run_mode(2, 10);
        push_sprite(10, 92, 0, 1'b0, 32);
        run_mode(2, 32);
        push_sprite(10, 92, 0, 1'b1, 32);
        run_mode(1, 32);

        // 145 updates: x 10 -> 155, style -> 1; one more -> 156, style 0.
        update = 1'b1;
        repeat (145) tick();
        update = 1'b0;
        do_update();
        load();
        push_sprite(156, 92, 0, 1'b0, 32);
        run_mode(2, 32);
        do_update();
        push_sprite(156, 92, 0, 1'b1, 32);
        run_mode(1, 32);
        load();
        push_sprite(0, 92, 1, 1'b0, 32);
        run_mode(2, 32);

        // Jump held for the whole flight: 92, 91..80, 81..92.
        jump = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            do_update();
            load();
            if (k == 1)       yexp = 92;
            else if (k <= 13) yexp = 93 - k;
            else              yexp = k + 67;
            push_sprite(k, yexp, 0, 1'b1, 1);
            run_mode(1, 1);
        end
        jump = 1'b0;
        do_update();
        load();
        push_sprite(26, 92, 0, 1'b1, 1);
        run_mode(1, 1);

        // Frame timing with a 4-cycle tick.
        reset_frame_counter = 1'b0;
        tick();
        reset_frame_counter = 1'b1;
        chk("frame_cleared", 32'(frameCounter), 32'd0);
        repeat (56) tick();
        chk("frame_after_56", 32'(frameCounter), 32'd14);
        repeat (3) tick();
        reset_frame_counter = 1'b0;
        tick();
        reset_frame_counter = 1'b1;
        chk("frame_clear_on_wrap", 32'(frameCounter), 32'd0);
        repeat (3) tick();
        chk("frame_delay_restart", 32'(frameCounter), 32'd0);
        tick();
        chk("frame_first_tick", 32'(frameCounter), 32'd1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
